// File: rtl/scope_pkg.sv
// Shared types and correction math for the scope capture/dump path.
package scope_pkg;

  typedef enum logic [2:0] {IDLE, RD, LAT, XMIT, WAIT_TX} dump_state_t;

  localparam int unsigned OG_W  = 16;
  localparam int unsigned SMP_W = 8;
  localparam int unsigned CH_W  = 3;

  // Offset, saturate to a byte, scale by gain/128, saturate again.
  function automatic logic [SMP_W-1:0] og_correct_fn(input logic [7:0] rdata,
                                                     input logic [7:0] offset,
                                                     input logic [7:0] gain);
    logic signed [9:0] sum;
    logic [7:0]        sat;
    logic [15:0]       prod;
    sum = $signed({2'b00, rdata}) + $signed({{2{offset[7]}}, offset});
    if (sum[9])
      sat = 8'h00;
    else if (sum[8])
      sat = 8'hFF;
    else
      sat = sum[7:0];
    prod = 16'(gain) * 16'(sat);
    return prod[15] ? 8'hFF : prod[14:7];
  endfunction

endpackage

// File: rtl/og_correct.sv
// Combinational offset/gain correction of one selected sample.
module og_correct
  import scope_pkg::*;
(
  input  logic [7:0] rdata,
  input  logic [7:0] offset,
  input  logic [7:0] gain,
  output logic [7:0] corr_c
);

  assign corr_c = og_correct_fn(rdata, offset, gain);

endmodule

// File: rtl/trace_dump_engine.sv
// Trace RAM port arbiter between capture writes and a circular dump walk,
// feeding corrected bytes to the UART transmitter.
module trace_dump_engine
  import scope_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic                     cap_en,
  input  logic [ADDR_W-1:0]        cap_addr,
  input  logic [ADDR_W-1:0]        trace_end,
  input  logic                     dump_req,
  input  logic                     dump_all,
  input  logic [CH_W-1:0]          dump_chan,
  input  logic [NUM_CH*OG_W-1:0]   og,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic                     tx_done,
  output logic                     en,
  output logic [ADDR_W-1:0]        addr,
  output logic                     ram_trmt,
  output logic [DATA_W-1:0]        ram_tx_data,
  output logic                     dump_busy,
  output logic                     dump_done
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  if (DATA_W != 8) begin : g_bad_data_w
    $error("trace_dump_engine: DATA_W must be 8");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("trace_dump_engine: NUM_CH must be 1..8");
  end

  dump_state_t       state, state_d;
  logic              mode_all, all_d;
  logic [CH_W-1:0]   ch, ch_d, chan_sel;
  logic [ADDR_W-1:0] cnt, cnt_d, addr_d, start_addr;
  logic [DATA_W-1:0] data_d, rdata_sel;
  logic [OG_W-1:0]   og_sel;
  logic [7:0]        corr_c;
  logic              en_d, trmt_d, busy_d, done_d;

  assign start_addr = trace_end + ADDR_W'(1);
  assign chan_sel   = (32'(dump_chan) >= NUM_CH) ? LAST_CH : dump_chan;

  // Channel mux ahead of the single correction datapath.
  assign rdata_sel = DATA_W'(ch_rdata >> (32'(ch) * DATA_W));
  assign og_sel    = OG_W'(og >> (32'(ch) * OG_W));

  og_correct u_og_correct (
    .rdata  (rdata_sel),
    .offset (og_sel[7:0]),
    .gain   (og_sel[15:8]),
    .corr_c (corr_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_all    <= 1'b0;
      ch          <= '0;
      cnt         <= '0;
      addr        <= '0;
      en          <= 1'b0;
      ram_trmt    <= 1'b0;
      ram_tx_data <= '0;
      dump_busy   <= 1'b0;
      dump_done   <= 1'b0;
    end else begin
      state       <= state_d;
      mode_all    <= all_d;
      ch          <= ch_d;
      cnt         <= cnt_d;
      addr        <= addr_d;
      en          <= en_d;
      ram_trmt    <= trmt_d;
      ram_tx_data <= data_d;
      dump_busy   <= busy_d;
      dump_done   <= done_d;
    end
  end

  // Next state plus the values every registered output takes next cycle.
  always_comb begin
    state_d = state;
    all_d   = mode_all;
    ch_d    = ch;
    cnt_d   = cnt;
    addr_d  = addr;
    data_d  = ram_tx_data;
    en_d    = 1'b0;
    trmt_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (we) begin
      state_d = IDLE;
      en_d    = cap_en;
      addr_d  = cap_addr;
    end else begin
      case (state)
        IDLE: begin
          if (dump_req) begin
            all_d   = dump_all;
            ch_d    = dump_all ? '0 : chan_sel;
            cnt_d   = '0;
            addr_d  = start_addr;
            state_d = RD;
          end
        end
        RD:   state_d = LAT;
        LAT: begin
          data_d  = corr_c;
          state_d = XMIT;
        end
        XMIT: state_d = WAIT_TX;
        WAIT_TX: begin
          if (tx_done) begin
            if (!(&cnt)) begin
              addr_d  = addr + ADDR_W'(1);
              cnt_d   = cnt + ADDR_W'(1);
              state_d = RD;
            end else if (mode_all && ch != LAST_CH) begin
              ch_d    = ch + CH_W'(1);
              addr_d  = start_addr;
              cnt_d   = '0;
              state_d = RD;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      en_d   = (state_d == RD);
      trmt_d = (state_d == XMIT);
      busy_d = (state_d != IDLE) || done_d;
    end
  end

endmodule

// File: tb/tb_trace_dump_engine.sv
// Self-checking bench for trace_dump_engine (NUM_CH=3, ADDR_W=4) against a timeline model.
module tb_trace_dump_engine;

  localparam int unsigned NC    = 3;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic            clk, rst_n, we, cap_en, dump_req, dump_all, tx_done;
  logic [AW-1:0]   cap_addr, trace_end, addr;
  logic [2:0]      dump_chan;
  logic [NC*16-1:0] og_v;
  logic [NC*8-1:0] ch_rdata;
  logic            en, ram_trmt, dump_busy, dump_done;
  logic [7:0]      ram_tx_data;

  logic [7:0] mem    [NC][DEPTH];
  logic [7:0] off_a  [NC];
  logic [7:0] gain_a [NC];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state
  bit         act;
  bit         m_all;
  int         m_chan, j, total, rd_cyc, done_cyc;
  logic [1:0] rd_ch;
  logic [3:0] rd_a;
  logic       m_en, m_trmt, m_busy, m_done;
  logic [3:0] m_addr;
  logic [7:0] m_data;

  // observation logs
  int         en_cyc_q[$];
  int         trmt_cyc_q[$];
  logic [3:0] en_addr_q[$];
  logic [7:0] trmt_data_q[$];
  int         done_cnt = 0;
  int         req_cyc, done_obs;
  int         resp_fixed;
  bit         resp_spur;

  trace_dump_engine #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .cap_en      (cap_en),
    .cap_addr    (cap_addr),
    .trace_end   (trace_end),
    .dump_req    (dump_req),
    .dump_all    (dump_all),
    .dump_chan   (dump_chan),
    .og          (og_v),
    .ch_rdata    (ch_rdata),
    .tx_done     (tx_done),
    .en          (en),
    .addr        (addr),
    .ram_trmt    (ram_trmt),
    .ram_tx_data (ram_tx_data),
    .dump_busy   (dump_busy),
    .dump_done   (dump_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    og_v = '0;
    for (int i = 0; i < NC; i++) og_v[i*16 +: 16] = {gain_a[i], off_a[i]};
  end

  // Trace RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (en) ch_rdata <= {mem[2][addr], mem[1][addr], mem[0][addr]};
  end

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  // Timeline model: byte j is read one cycle after the request or after the
  // accepted tx_done of byte j-1, transmitted two cycles after its read.
  initial begin
    forever begin
      int c, n;
      @(posedge clk);
      c = cyc;
      n = c + 1;
      cyc = n;
      if (!rst_n) begin
        act = 0; done_cyc = -1; rd_cyc = -10;
        m_en = 0; m_addr = '0; m_trmt = 0; m_data = '0; m_busy = 0; m_done = 0;
      end else if (we) begin
        act = 0; done_cyc = -1;
        m_en = cap_en; m_addr = cap_addr; m_trmt = 0; m_busy = 0; m_done = 0;
      end else begin
        if (!act && dump_req) begin
          act    = 1;
          j      = 0;
          m_all  = dump_all;
          m_chan = (32'(dump_chan) >= NC) ? NC - 1 : 32'(dump_chan);
          total  = m_all ? NC * DEPTH : DEPTH;
          rd_cyc = n;
        end else if (act && tx_done && c >= rd_cyc + 3) begin
          j++;
          if (j == total) begin
            act = 0;
            done_cyc = n;
          end else begin
            rd_cyc = n;
          end
        end
        m_en = act && (n == rd_cyc);
        if (m_en) begin
          rd_ch  = 2'(m_all ? j / DEPTH : m_chan);
          rd_a   = 4'((32'(trace_end) + 1 + 32'(j) % DEPTH) % DEPTH);
          m_addr = rd_a;
        end
        m_trmt = act && (n == rd_cyc + 2);
        if (m_trmt) m_data = scope_pkg::og_correct_fn(mem[rd_ch][rd_a], off_a[rd_ch], gain_a[rd_ch]);
        m_busy = act || (n == done_cyc);
        m_done = (n == done_cyc);
      end
    end
  end

  // Per-cycle compare against the model, plus logging for literal checks.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("en",        32'(en),          32'(m_en));
        chk("addr",      32'(addr),        32'(m_addr));
        chk("ram_trmt",  32'(ram_trmt),    32'(m_trmt));
        chk("tx_data",   32'(ram_tx_data), 32'(m_data));
        chk("dump_busy", 32'(dump_busy),   32'(m_busy));
        chk("dump_done", 32'(dump_done),   32'(m_done));
        if (en === 1'b1) begin
          en_cyc_q.push_back(cyc);
          en_addr_q.push_back(addr);
        end
        if (ram_trmt === 1'b1) begin
          trmt_cyc_q.push_back(cyc);
          trmt_data_q.push_back(ram_tx_data);
        end
        if (dump_done === 1'b1) done_cnt++;
      end
    end
  end

  // UART stand-in: answers each strobe with tx_done after a delay, optionally
  // also asserting it in the strobe cycle itself.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ram_trmt === 1'b1) begin
        int d;
        bit spur;
        d    = (resp_fixed > 0) ? resp_fixed : int'($urandom_range(1, 6));
        spur = resp_spur && ($urandom_range(0, 1) == 1);
        for (int i = 0; i <= d; i++) begin
          tx_done = (i == d) || (spur && i == 0);
          @(negedge clk);
        end
        tx_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic fill_rand();
    for (int c = 0; c < NC; c++) begin
      off_a[c]  = 8'($urandom);
      gain_a[c] = 8'($urandom);
      for (int a = 0; a < DEPTH; a++) mem[c][a] = 8'($urandom);
    end
  endtask

  task automatic start_dump(input logic all, input logic [2:0] ch, input logic [3:0] te);
    trace_end = te;
    dump_all  = all;
    dump_chan = ch;
    en_cyc_q.delete();
    en_addr_q.delete();
    trmt_cyc_q.delete();
    trmt_data_q.delete();
    dump_req = 1'b1;
    req_cyc  = cyc;
    @(negedge clk);
    dump_req = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (dump_done !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(dump_done), 32'd1);
    done_obs = cyc;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_dump(input logic all, input logic [2:0] ch, input logic [3:0] te, input bit extra);
    start_dump(all, ch, te);
    if (extra) begin
      repeat (4) @(negedge clk);
      dump_req = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
    end
    wait_done(2000);
  endtask

  initial begin
    int dn, k;
    rst_n = 1'b0; we = 1'b0; cap_en = 1'b0; cap_addr = '0; trace_end = '0;
    dump_req = 1'b0; dump_all = 1'b0; dump_chan = '0;
    resp_fixed = 0; resp_spur = 0;
    for (int c = 0; c < NC; c++) begin
      off_a[c] = '0; gain_a[c] = '0;
      for (int a = 0; a < DEPTH; a++) mem[c][a] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_en",   32'(en),          32'd0);
    chk("rst_addr", 32'(addr),        32'd0);
    chk("rst_trmt", 32'(ram_trmt),    32'd0);
    chk("rst_data", 32'(ram_tx_data), 32'd0);
    chk("rst_busy", 32'(dump_busy),   32'd0);
    chk("rst_done", 32'(dump_done),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: request at cycle 0, tx_done 7 cycles after each strobe.
    fill_rand();
    resp_fixed = 7;
    do_dump(1'b0, 3'd0, 4'h3, 1'b0);
    chk("lat_en",    32'(en_cyc_q[0] - req_cyc),      32'd1);
    chk("lat_trmt",  32'(trmt_cyc_q[0] - req_cyc),    32'd3);
    chk("lat_trmt2", 32'(trmt_cyc_q[1] - req_cyc),    32'd13);
    chk("lat_done",  32'(done_obs - trmt_cyc_q[15]),  32'd8);

    // Circular walk from the oldest sample, single channel 1.
    fill_rand();
    resp_fixed = 5;
    do_dump(1'b0, 3'd1, 4'hE, 1'b0);
    chk("walk_nrd",   32'(en_addr_q.size()),   32'd16);
    chk("walk_ntx",   32'(trmt_data_q.size()), 32'd16);
    chk("walk_a0",    32'(en_addr_q[0]),       32'hF);
    chk("walk_a1",    32'(en_addr_q[1]),       32'h0);
    chk("walk_a15",   32'(en_addr_q[15]),      32'hE);
    chk("walk_space", 32'(trmt_cyc_q[1] - trmt_cyc_q[0]), 32'd8);
    chk("walk_done",  32'(done_obs - trmt_cyc_q[15]),     32'd6);

    // Correction corner cases.
    resp_fixed = 1;
    fill_rand();
    for (int a = 0; a < DEPTH; a++) mem[1][a] = 8'h40;
    off_a[1] = 8'h80; gain_a[1] = 8'h80;
    do_dump(1'b0, 3'd1, 4'h7, 1'b0);
    chk("corr_neg0",  32'(trmt_data_q[0]),  32'h00);
    chk("corr_neg15", 32'(trmt_data_q[15]), 32'h00);

    fill_rand();
    for (int a = 0; a < DEPTH; a++) mem[1][a] = 8'hF0;
    off_a[1] = 8'h7F; gain_a[1] = 8'h80;
    do_dump(1'b0, 3'd1, 4'h2, 1'b0);
    chk("corr_sat0", 32'(trmt_data_q[0]), 32'hFF);
    chk("corr_sat9", 32'(trmt_data_q[9]), 32'hFF);

    // dump_chan beyond NUM_CH clamps to the last channel.
    fill_rand();
    for (int a = 0; a < DEPTH; a++) begin
      mem[2][a] = 8'h80;
      mem[1][a] = 8'h11;
    end
    off_a[2] = 8'h00; gain_a[2] = 8'h40;
    do_dump(1'b0, 3'd7, 4'h0, 1'b0);
    chk("clamp_n",   32'(trmt_data_q.size()), 32'd16);
    chk("clamp_b0",  32'(trmt_data_q[0]),     32'h40);
    chk("clamp_b15", 32'(trmt_data_q[15]),    32'h40);

    // All-channel dump: 48 bytes, address restarts per channel.
    fill_rand();
    resp_fixed = 0;
    do_dump(1'b1, 3'd1, 4'h9, 1'b0);
    chk("all_nrd",  32'(en_addr_q.size()),   32'd48);
    chk("all_ntx",  32'(trmt_data_q.size()), 32'd48);
    chk("all_a0",   32'(en_addr_q[0]),       32'hA);
    chk("all_a16",  32'(en_addr_q[16]),      32'hA);
    chk("all_a32",  32'(en_addr_q[32]),      32'hA);
    chk("all_a47",  32'(en_addr_q[47]),      32'h9);

    // Capture takes the port mid-dump; the request during capture is ignored.
    fill_rand();
    start_dump(1'b0, 3'd0, 4'h4);
    repeat (20) @(negedge clk);
    chk("we_busy_pre", 32'(dump_busy), 32'd1);
    we = 1'b1; cap_en = 1'b1; cap_addr = 4'h5; dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    chk("we_en",   32'(en),        32'd1);
    chk("we_addr", 32'(addr),      32'h5);
    chk("we_busy", 32'(dump_busy), 32'd0);
    we = 1'b0; cap_en = 1'b0;
    dn = done_cnt;
    repeat (40) @(negedge clk);
    chk("we_no_done", 32'(done_cnt),  32'(dn));
    chk("we_idle",    32'(dump_busy), 32'd0);

    // Reset pulse while waiting for tx_done.
    fill_rand();
    resp_fixed = 6;
    start_dump(1'b1, 3'd0, 4'hB);
    k = 0;
    while (ram_trmt !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rstm_trmt_seen", 32'(ram_trmt), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstm_en",   32'(en),          32'd0);
    chk("rstm_addr", 32'(addr),        32'd0);
    chk("rstm_trmt", 32'(ram_trmt),    32'd0);
    chk("rstm_data", 32'(ram_tx_data), 32'd0);
    chk("rstm_busy", 32'(dump_busy),   32'd0);
    repeat (20) @(negedge clk);
    chk("rstm_no_trmt", 32'(trmt_cyc_q.size()), 32'd1);

    // Randomized dumps with stray tx_done and requests while busy.
    resp_fixed = 0;
    resp_spur  = 1;
    for (int t = 0; t < 6; t++) begin
      fill_rand();
      do_dump(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
